// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle MIPS control unit:
// state codes, opcode/funct values, ALU and PC-source selects, decode and strobe bundles.
package mc_pkg;

    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_EXEC_M  = 4'd2;
    localparam logic [3:0] ST_MEM_L   = 4'd3;
    localparam logic [3:0] ST_WRITE   = 4'd4;
    localparam logic [3:0] ST_MEM_S   = 4'd5;
    localparam logic [3:0] ST_EXEC_R  = 4'd6;
    localparam logic [3:0] ST_MEM_R   = 4'd7;
    localparam logic [3:0] ST_EXEC_I  = 4'd8;
    localparam logic [3:0] ST_MEM_I   = 4'd9;
    localparam logic [3:0] ST_EXEC_B  = 4'd10;
    localparam logic [3:0] ST_EXEC_J  = 4'd11;
    localparam logic [3:0] ST_DELAY   = 4'd12;
    localparam logic [3:0] ST_TRAP    = 4'd14;
    localparam logic [3:0] ST_ILLEGAL = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [2:0] OP_IALU_HI = 3'b001;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [2:0] ALU_OP_I   = 3'd0;
    localparam logic [2:0] ALU_OP_MEM = 3'd1;
    localparam logic [2:0] ALU_OP_BR  = 3'd2;
    localparam logic [2:0] ALU_OP_R   = 3'd3;
    localparam logic [2:0] ALU_OP_ADD = 3'd4;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    localparam logic [1:0] ALUB_B      = 2'd0;
    localparam logic [1:0] ALUB_FOUR   = 2'd1;
    localparam logic [1:0] ALUB_IMM    = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH = 2'd3;

    typedef struct packed {
        logic is_r;
        logic is_jr;
        logic is_j;
        logic is_b;
        logic is_l;
        logic is_s;
        logic is_i;
        logic is_illegal;
    } instr_class_t;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/mc_instr_decode.sv
// Combinational instruction classifier: maps the instruction register onto one-hot
// class flags used by the control FSM.
module mc_instr_decode
    import mc_pkg::*;
#(
    parameter bit JR_EN = 1'b1
) (
    input  logic [31:0]  instr,
    output instr_class_t cls
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_bits;

    assign op    = opcode_of(instr);
    assign funct = instr[5:0];
    // Register and immediate fields are irrelevant to control; sink them explicitly.
    assign unused_bits = ^instr[25:6];

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        cls = '0;
        if (op == OP_RTYPE) begin
            if (JR_EN && funct == FUNCT_JR) cls.is_jr = 1'b1;
            else                            cls.is_r  = 1'b1;
        end else if (op == OP_J) begin
            cls.is_j = 1'b1;
        end else if (op == OP_BEQ || op == OP_BNE) begin
            cls.is_b = 1'b1;
        end else if (op == OP_LW) begin
            cls.is_l = 1'b1;
        end else if (op == OP_SW) begin
            cls.is_s = 1'b1;
        end else if (op[5:3] == OP_IALU_HI) begin
            cls.is_i = 1'b1;
        end else begin
            cls.is_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with memory handshake, wait watchdog, optional
// branch delay state, jr support, sticky illegal/timeout traps and a retire pulse.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter bit          DELAY_SLOT    = 1'b1,
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned WAIT_LIMIT    = 15,
    parameter bit          JR_EN         = 1'b1
) (
    input  logic        cclk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic [3:0]  state,
    output logic        pc_write,
    output logic [1:0]  pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        ir_write,
    output logic        alu_src_a,
    output logic        reg_write,
    output logic        reg_dst,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [2:0]  alu_op,
    output logic        illegal,
    output logic        mem_timeout,
    output logic        retired
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             illegal_q, illegal_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic             retired_q, retired_d;

    instr_class_t cls;
    ctrl_t        ctrl;
    logic         ready;
    logic         mem_state;
    logic         at_limit;
    logic         is_bne;
    logic [3:0]   after_branch;
    logic [2:0]   alu_class;

    mc_instr_decode #(.JR_EN(JR_EN)) u_decode (
        .instr (instr),
        .cls   (cls)
    );

    assign ready        = mem_ready | ~MEM_HANDSHAKE;
    assign mem_state    = (state_q == ST_FETCH) || (state_q == ST_MEM_L) || (state_q == ST_MEM_S);
    assign at_limit     = (wait_cnt_q == CNT_W'(WAIT_LIMIT));
    assign is_bne       = cls.is_b && (opcode_of(instr) == OP_BNE);
    assign after_branch = DELAY_SLOT ? ST_DELAY : ST_FETCH;
    assign alu_class    = (cls.is_r || cls.is_jr) ? ALU_OP_R   :
                          cls.is_b                ? ALU_OP_BR  :
                          (cls.is_l || cls.is_s)  ? ALU_OP_MEM : ALU_OP_I;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            wait_cnt_q    <= '0;
            illegal_q     <= 1'b0;
            mem_timeout_q <= 1'b0;
            retired_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            illegal_q     <= illegal_d;
            mem_timeout_q <= mem_timeout_d;
            retired_q     <= retired_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        illegal_d     = illegal_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_FETCH:  if (ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (cls.is_jr || cls.is_j)    state_d = ST_EXEC_J;
                else if (cls.is_r)            state_d = ST_EXEC_R;
                else if (cls.is_b)            state_d = ST_EXEC_B;
                else if (cls.is_l || cls.is_s) state_d = ST_EXEC_M;
                else if (cls.is_i)            state_d = ST_EXEC_I;
                else begin
                    state_d   = ST_ILLEGAL;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC_M: state_d = cls.is_l ? ST_MEM_L : ST_MEM_S;
            ST_MEM_L:  if (ready) state_d = ST_WRITE;
            ST_MEM_S:  if (ready) state_d = after_branch;
            ST_EXEC_B, ST_EXEC_J: state_d = after_branch;
            ST_EXEC_R: state_d = ST_MEM_R;
            ST_EXEC_I: state_d = ST_MEM_I;
            ST_WRITE, ST_MEM_R, ST_MEM_I, ST_DELAY: state_d = ST_FETCH;
            ST_TRAP, ST_ILLEGAL: state_d = state_q;
            default:   state_d = ST_TRAP;
        endcase

        // Ready in the limit cycle completes normally; only a stall at the limit traps.
        if (mem_state && !ready) begin
            if (at_limit) begin
                state_d       = ST_TRAP;
                mem_timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    assign retired_d = (state_q != ST_FETCH) && (state_d == ST_FETCH);

    always_comb begin
        ctrl = '0;
        if (state_q <= ST_DELAY) ctrl.alu_op = alu_class;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = ready;
                ctrl.pc_write  = ready;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = ALUB_IMM_SH;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            ST_EXEC_M, ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
            end
            ST_MEM_L: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_MEM_S: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            ST_WRITE: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_MEM_I: ctrl.reg_write = 1'b1;
            ST_EXEC_B: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = {is_bne, cls.is_b & ~is_bne};
            end
            ST_EXEC_J: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = cls.is_jr ? PCSRC_REG : PCSRC_JUMP;
            end
            default: ;
        endcase
        if (rst) ctrl = '0;
    end

    assign state         = state_q;
    assign illegal       = illegal_q;
    assign mem_timeout   = mem_timeout_q;
    assign retired       = retired_q;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign ir_write      = ctrl.ir_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;

endmodule
